pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 10, program counter width in instruction words.
REQ-002 Parameter IN_WIDTH, default 16, width of the external input value.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 cu_Jump  input  1  jump request from control unit.
REQ-006 cu_Branch  input  1  branch-on-equal request from control unit.
REQ-007 cu_inSignal  input  1  In instruction in progress.
REQ-008 cu_hlt  input  1  stop request from control unit.
REQ-009 alu_zero  input  1  ALU zero flag for the current instruction.
REQ-010 jump_addr  input  PC_WIDTH  absolute jump target.
REQ-011 branch_off  input  16  signed branch offset in words.
REQ-012 in_valid  input  1  external input ready (level, e.g. enter key).
REQ-013 in_data  input  IN_WIDTH  external input value.
REQ-014 resume  input  1  leave HALT (only with HALT_RESUME_EN).
REQ-015 pc  output  PC_WIDTH  current instruction address, registered.
REQ-016 pc_stall  output  1  high while PC is held waiting for input; gates register write.
REQ-017 in_ack  output  1  one-cycle pulse: input accepted, in_value valid.
REQ-018 in_value  output  IN_WIDTH  latched external input.
REQ-019 halted  output  1  high in HALT.

Function
REQ-020 States SHALL be RUN, WAIT_IN, HALT; one transition per clock at most.
REQ-021 In RUN, next-PC priority SHALL be: cu_hlt > cu_inSignal > cu_Jump > (cu_Branch & alu_zero) > pc+1.
- cu_hlt: pc held, go HALT; all other control inputs don't-care.
- cu_inSignal: pc held, go WAIT_IN, pc_stall=1 from next cycle.
- cu_Jump: pc <= jump_addr.
- cu_Branch & alu_zero: pc <= pc+1+sign_extend(branch_off), truncated to PC_WIDTH.
- cu_Branch & !alu_zero, or no request: pc <= pc+1.
REQ-022 All PC arithmetic SHALL be modulo 2^PC_WIDTH; pc+1 at all-ones wraps to 0.
REQ-023 An internal armed flag SHALL be set whenever in_valid is sampled low and cleared on acceptance; reset sets it to 0.
REQ-024 In WAIT_IN, on an edge where in_valid=1 and armed=1: in_value <= in_data, in_ack=1 for exactly the following cycle, pc <= pc+1, pc_stall <= 0, state <= RUN.
REQ-025 In WAIT_IN with in_valid=0 or armed=0: pc, in_value held; pc_stall stays 1; control inputs ignored.
REQ-026 A held in_valid SHALL NOT satisfy two consecutive In instructions; the second waits for a low-then-high in_valid.
REQ-027 In HALT, pc and in_value held, halted=1, all control inputs ignored (except per REQ-032).
REQ-028 in_ack SHALL be 0 in every cycle not defined by REQ-024.

Reset
REQ-029 rst_n=0 at an edge SHALL force pc=0, state=RUN, pc_stall=0, in_ack=0, in_value=0, halted=0, armed=0, overriding all other inputs including mid-WAIT_IN and HALT.
REQ-030 First instruction fetch after reset release SHALL be address 0.

Configuration
REQ-031 Macro HALT_RESUME_EN SHALL select HALT exit behaviour.
REQ-032 Defined: in HALT, resume=1 at an edge sets pc <= pc+1, halted <= 0, state <= RUN.
REQ-033 Undefined: HALT exits only via reset; resume ignored (port still present).

Verification
REQ-034 Reset, 5 cycles no requests -> pc 0,1,2,3,4,5; pc_stall=0, in_ack=0.
REQ-035 pc=7, cu_Branch=1, alu_zero=1, branch_off=-3 -> pc=5; same with alu_zero=0 -> pc=8.
REQ-036 pc=2, cu_Jump=1, cu_Branch=1, alu_zero=1, jump_addr=100 -> pc=100 (jump wins).
REQ-037 pc=4, cu_inSignal=1, in_valid=1 held from reset -> stall until in_valid low one cycle then high with in_data=0x00A5 -> in_value=0x00A5, in_ack one cycle, pc=5.
REQ-038 pc=1023 (PC_WIDTH=10), no request -> pc=0; pc=3, cu_hlt=1 with cu_Jump=1 -> pc stays 3, halted=1.
REQ-039 In HALT, resume=1 -> with HALT_RESUME_EN pc+1 and RUN; without, pc unchanged; then rst_n=0 -> pc=0, halted=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer: RUN / WAIT_IN / HALT control of the PC.
// RUN priority: halt > input wait > jump > taken branch > pc+1.
// An input is accepted only after in_valid has been seen low (armed), so a
// level held across two In instructions cannot satisfy both of them.
// Optional build macro HALT_RESUME_EN: when defined, resume leaves HALT and
// advances the PC. When it is undefined, HALT is left only through reset.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH = 10,
  parameter int unsigned IN_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cu_Jump,
  input  logic                cu_Branch,
  input  logic                cu_inSignal,
  input  logic                cu_hlt,
  input  logic                alu_zero,
  input  logic [PC_WIDTH-1:0] jump_addr,
  input  logic [15:0]         branch_off,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_stall,
  output logic                in_ack,
  output logic [IN_WIDTH-1:0] in_value,
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_IN,
    ST_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IN_WIDTH-1:0] in_value_q, in_value_d;
  logic                in_ack_q, in_ack_d;
  logic                armed_q, armed_d;
  logic                accept;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_branch;

  // Sign-extend or truncate the word offset to PC width; sums wrap naturally.
  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign pc_branch = pc_inc + PC_WIDTH'(signed'(branch_off));

`ifndef HALT_RESUME_EN
  logic unused_resume;
  assign unused_resume = resume;
`endif

  // State register and datapath flops, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      in_value_q <= '0;
      in_ack_q   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      in_value_q <= in_value_d;
      in_ack_q   <= in_ack_d;
      armed_q    <= armed_d;
    end
  end

  // Next state, next PC, input capture and arming.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    in_value_d = in_value_q;
    in_ack_d   = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (cu_hlt) begin
          state_d = ST_HALT;
        end else if (cu_inSignal) begin
          state_d = ST_WAIT_IN;
        end else if (cu_Jump) begin
          pc_d = jump_addr;
        end else if (cu_Branch && alu_zero) begin
          pc_d = pc_branch;
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_WAIT_IN: begin
        if (in_valid && armed_q) begin
          accept     = 1'b1;
          in_value_d = in_data;
          in_ack_d   = 1'b1;
          pc_d       = pc_inc;
          state_d    = ST_RUN;
        end
      end
      ST_HALT: begin
`ifdef HALT_RESUME_EN
        if (resume) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
`endif
      end
      default: state_d = ST_RUN;
    endcase
    // Acceptance needs in_valid high, so the low-sample set never collides.
    if (!in_valid) begin
      armed_d = 1'b1;
    end else if (accept) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  // State-decoded status outputs.
  always_comb begin
    pc_stall = (state_q == ST_WAIT_IN);
    halted   = (state_q == ST_HALT);
  end

  assign pc       = pc_q;
  assign in_ack   = in_ack_q;
  assign in_value = in_value_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations,
// then randomized control/input traffic checked every cycle against a
// behavioural model.
module tb_pc_sequencer;

  localparam int PCW   = 10;
  localparam int INW   = 16;
  localparam int PCMOD = 1 << PCW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cu_Jump, cu_Branch, cu_inSignal, cu_hlt, alu_zero;
  logic [PCW-1:0] jump_addr;
  logic [15:0]    branch_off;
  logic           in_valid;
  logic [INW-1:0] in_data;
  logic           resume;
  logic [PCW-1:0] pc;
  logic           pc_stall, in_ack, halted;
  logic [INW-1:0] in_value;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int          m_pc;
  bit          m_wait, m_halt, m_armed, m_ack;
  logic [15:0] m_val;
  int          halt_cycles = 0;

  pc_sequencer #(.PC_WIDTH(PCW), .IN_WIDTH(INW)) dut (
    .clk(clk), .rst_n(rst_n), .cu_Jump(cu_Jump), .cu_Branch(cu_Branch),
    .cu_inSignal(cu_inSignal), .cu_hlt(cu_hlt), .alu_zero(alu_zero),
    .jump_addr(jump_addr), .branch_off(branch_off), .in_valid(in_valid),
    .in_data(in_data), .resume(resume), .pc(pc), .pc_stall(pc_stall),
    .in_ack(in_ack), .in_value(in_value), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: advance one clock using the rules directly.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0; m_wait = 0; m_halt = 0; m_armed = 0; m_ack = 0; m_val = '0;
    end else begin
      m_ack = 0;
      if (m_halt) begin
`ifdef HALT_RESUME_EN
        if (resume) begin
          m_pc = (m_pc + 1) % PCMOD;
          m_halt = 0;
        end
`endif
      end else if (m_wait) begin
        if (in_valid && m_armed) begin
          m_val = in_data; m_ack = 1; m_pc = (m_pc + 1) % PCMOD;
          m_wait = 0; m_armed = 0;
        end
      end else if (cu_hlt) begin
        m_halt = 1;
      end else if (cu_inSignal) begin
        m_wait = 1;
      end else if (cu_Jump) begin
        m_pc = int'(jump_addr);
      end else if (cu_Branch && alu_zero) begin
        int t;
        t = m_pc + 1 + int'($signed(branch_off));
        m_pc = ((t % PCMOD) + PCMOD) % PCMOD;
      end else begin
        m_pc = (m_pc + 1) % PCMOD;
      end
      if (!in_valid) m_armed = 1;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("pc_stall", 32'(pc_stall), 32'(m_wait));
      check("in_ack", 32'(in_ack), 32'(m_ack));
      check("in_value", 32'(in_value), 32'(m_val));
      check("halted", 32'(halted), 32'(m_halt));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cu_Jump = 0; cu_Branch = 0; cu_inSignal = 0; cu_hlt = 0; alu_zero = 0;
    resume = 0;
  endtask

  initial begin
    rst_n = 0; idle(); jump_addr = '0; branch_off = '0; in_data = '0;
    in_valid = 1;  // held high from reset
    @(negedge clk);
    step();
    chk_en = 1;
    check("rst_pc", 32'(pc), 0);
    check("rst_stall", 32'(pc_stall), 0);
    check("rst_ack", 32'(in_ack), 0);
    rst_n = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("count_pc", 32'(pc), 32'(k));
    end

    // In instruction at pc=4 with in_valid held since reset
    cu_Jump = 1; jump_addr = 4; step(); cu_Jump = 0;
    cu_inSignal = 1; step(); cu_inSignal = 0;
    check("wait_stall", 32'(pc_stall), 1);
    cu_Jump = 1; jump_addr = 50;
    repeat (3) step();
    cu_Jump = 0;
    check("held_valid_pc", 32'(pc), 4);
    check("held_valid_stall", 32'(pc_stall), 1);
    in_valid = 0; step();
    in_valid = 1; in_data = 16'h00A5; step();
    check("acc_ack", 32'(in_ack), 1);
    check("acc_value", 32'(in_value), 32'h00A5);
    check("acc_pc", 32'(pc), 5);
    check("acc_stall", 32'(pc_stall), 0);
    step();
    check("ack_pulse_end", 32'(in_ack), 0);
    check("after_acc_pc", 32'(pc), 6);

    // Second In instruction must not reuse the still-high in_valid
    cu_inSignal = 1; step(); cu_inSignal = 0;
    repeat (3) step();
    check("second_in_stall", 32'(pc_stall), 1);
    check("second_in_ack", 32'(in_ack), 0);
    in_valid = 0; step();
    in_valid = 1; in_data = 16'h1234; step();
    check("second_value", 32'(in_value), 32'h1234);
    check("second_pc", 32'(pc), 7);

    // Branch taken / not taken
    cu_Branch = 1; alu_zero = 1; branch_off = 16'hFFFD; step();
    check("branch_taken", 32'(pc), 5);
    idle(); cu_Jump = 1; jump_addr = 7; step(); idle();
    cu_Branch = 1; alu_zero = 0; step(); idle();
    check("branch_not_taken", 32'(pc), 8);

    // Jump beats branch
    cu_Jump = 1; jump_addr = 2; step();
    cu_Branch = 1; alu_zero = 1; jump_addr = 100; branch_off = 16'd5; step(); idle();
    check("jump_priority", 32'(pc), 100);

    // Wrap at all-ones
    cu_Jump = 1; jump_addr = 10'h3FF; step(); idle();
    step();
    check("wrap", 32'(pc), 0);

    // Halt beats jump; halt holds pc
    cu_Jump = 1; jump_addr = 3; step();
    cu_hlt = 1; jump_addr = 9; step(); cu_hlt = 0;
    check("halt_pc", 32'(pc), 3);
    check("halt_flag", 32'(halted), 1);
    repeat (2) step();
    idle();
    check("halt_hold", 32'(pc), 3);
    resume = 1; step(); resume = 0;
`ifdef HALT_RESUME_EN
    check("resume_pc", 32'(pc), 4);
    check("resume_halted", 32'(halted), 0);
`else
    check("resume_ignored_pc", 32'(pc), 3);
    check("resume_ignored_halted", 32'(halted), 1);
`endif
    rst_n = 0; step(); rst_n = 1;
    check("halt_reset_pc", 32'(pc), 0);
    check("halt_reset_halted", 32'(halted), 0);

    // Reset in the middle of an input wait
    cu_inSignal = 1; step(); idle();
    check("mid_wait_stall", 32'(pc_stall), 1);
    rst_n = 0; step(); rst_n = 1;
    check("mid_wait_reset_stall", 32'(pc_stall), 0);
    check("mid_wait_reset_pc", 32'(pc), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
      rst_n       = !(($urandom_range(0, 149) == 0) || halt_cycles > 12);
      cu_hlt      = ($urandom_range(0, 59) == 0);
      cu_inSignal = ($urandom_range(0, 7) == 0);
      cu_Jump     = ($urandom_range(0, 5) == 0);
      cu_Branch   = ($urandom_range(0, 3) == 0);
      alu_zero    = $urandom_range(0, 1) == 1;
      jump_addr   = PCW'($urandom);
      branch_off  = 16'($urandom);
      in_data     = 16'($urandom);
      resume      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) in_valid = !in_valid;
      step();
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
